// File: rtl/qpmm_sched.sv
// qpmm_sched: round-robin issue of NREQ requesters onto one fixed-latency,
// fully pipelined QPMM multiplier, with per-requester credits and in-order return.
module qpmm_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 272,
    parameter int TW      = 4,
    parameter int LAT     = 48,
    parameter int MAX_OUT = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ*TW-1:0]  req_tag,
    output logic                mul_valid,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic [W-1:0]        mul_z,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [TW-1:0]       rsp_tag,
    output logic [W-1:0]        rsp_z,
    output logic                busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt [NREQ];
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   sel_id;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [TW-1:0]   sel_tag;

    logic [IW-1:0]   iss_id;
    logic [TW-1:0]   iss_tag;

    logic [LAT-1:0]  trk_v;
    logic [IW-1:0]   trk_id  [LAT];
    logic [TW-1:0]   trk_tag [LAT];
    logic [NREQ-1:0] rsp_next;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && (cnt[i] < CW'(MAX_OUT));
        end
    end

    // Rotating search from ptr; the first eligible requester wins.
    always_comb begin
        grant  = '0;
        accept = 1'b0;
        sel_id = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((32'(ptr) + k) % NREQ);
            if (!accept && elig[idx]) begin
                accept      = 1'b1;
                grant[idx]  = 1'b1;
                sel_id      = idx;
            end
        end
        if (!rstn) begin
            grant  = '0;
            accept = 1'b0;
        end
    end

    assign req_ready = grant;

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_tag = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a   = sel_a   | req_a[i*W +: W];
                sel_b   = sel_b   | req_b[i*W +: W];
                sel_tag = sel_tag | req_tag[i*TW +: TW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr       <= '0;
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            iss_id    <= '0;
            iss_tag   <= '0;
        end else begin
            mul_valid <= accept;
            if (accept) begin
                ptr     <= (sel_id == IW'(NREQ - 1)) ? '0 : sel_id + IW'(1);
                mul_a   <= sel_a;
                mul_b   <= sel_b;
                iss_id  <= sel_id;
                iss_tag <= sel_tag;
            end
        end
    end

    // Tracking starts behind the issue register so its last stage lines up
    // with the cycle in which mul_z carries that operation's result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            trk_v <= '0;
        end else begin
            trk_v[0] <= mul_valid;
            for (int unsigned i = 1; i < LAT; i++) begin
                trk_v[i] <= trk_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        trk_id[0]  <= iss_id;
        trk_tag[0] <= iss_tag;
        for (int unsigned i = 1; i < LAT; i++) begin
            trk_id[i]  <= trk_id[i-1];
            trk_tag[i] <= trk_tag[i-1];
        end
    end

    always_comb begin
        rsp_next = '0;
        if (trk_v[LAT-1]) begin
            rsp_next[trk_id[LAT-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_tag   <= '0;
            rsp_z     <= '0;
        end else begin
            rsp_valid <= rsp_next;
            if (trk_v[LAT-1]) begin
                rsp_tag <= trk_tag[LAT-1];
                rsp_z   <= mul_z;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!rstn) begin
                cnt[i] <= '0;
            end else if (grant[i] && !rsp_valid[i]) begin
                cnt[i] <= cnt[i] + CW'(1);
            end else if (!grant[i] && rsp_valid[i]) begin
                cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

    assign busy = (|trk_v) | (|rsp_valid) | mul_valid;

    for (genvar g = 0; g < NREQ; g++) begin : g_credit_chk
        a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
            rsp_valid[g] |-> (cnt[g] != '0));
        a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
            cnt[g] <= CW'(MAX_OUT));
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(req_ready));

endmodule

// File: tb/tb_qpmm_sched.sv
// Directed and random bench for qpmm_sched; the multiplier is modelled as a
// LAT-deep pipeline computing a+b so every result is predictable.
module tb_qpmm_sched;

    localparam int NREQ    = 4;
    localparam int W       = 272;
    localparam int TW      = 4;
    localparam int LAT     = 48;
    localparam int MAX_OUT = 8;
    localparam int RAND_CYC = 10000;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ*TW-1:0]  req_tag;
    logic                mul_valid;
    logic [W-1:0]        mul_a;
    logic [W-1:0]        mul_b;
    logic [W-1:0]        mul_z;
    logic [NREQ-1:0]     rsp_valid;
    logic [TW-1:0]       rsp_tag;
    logic [W-1:0]        rsp_z;
    logic                busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] pipe [LAT];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe[0] <= mul_a + mul_b;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_z = pipe[LAT-1];

    qpmm_sched #(
        .NREQ(NREQ), .W(W), .TW(TW), .LAT(LAT), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_z(rsp_z),
        .busy(busy)
    );

    typedef struct {
        int           id;
        logic [TW-1:0] tag;
        logic [W-1:0] z;
        int           due;
    } ent_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] t);
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
        req_tag[i*TW +: TW] = t;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        req_tag = '0;
        #2;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready_pre actual=%b expected=0000", req_ready);
        end
        step();
        step();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready actual=%b expected=0000", req_ready);
        end
        checks++;
        if (mul_valid !== 1'b0 || rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids mul_valid=%b rsp_valid=%b busy=%b expected all 0",
                     mul_valid, rsp_valid, busy);
        end
        checks++;
        if (mul_a !== '0 || mul_b !== '0 || rsp_z !== '0 || rsp_tag !== '0) begin
            errors++;
            $display("FAIL reset_data mul_a=%h mul_b=%h rsp_z=%h rsp_tag=%h expected 0",
                     mul_a, mul_b, rsp_z, rsp_tag);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant actual=%b expected=0001", req_ready);
        end
        step();
        req_valid = '0;
    endtask

    task automatic test_single();
        bit early;
        apply_reset();
        set_op(0, W'(11), W'(13), 4'd1);
        set_op(1, W'(17), W'(19), 4'd2);
        set_op(2, W'(3),  W'(7),  4'd5);
        set_op(3, W'(23), W'(29), 4'd3);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready actual=%b expected=0100", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if (mul_valid !== 1'b1 || mul_a !== W'(3) || mul_b !== W'(7)) begin
            errors++;
            $display("FAIL single_issue mul_valid=%b a=%0d b=%0d expected 1 3 7",
                     mul_valid, mul_a, mul_b);
        end
        early = 0;
        for (int k = 2; k <= LAT + 1; k++) begin
            step();
            #1;
            if (rsp_valid !== 4'b0000) early = 1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL single_early_rsp actual=rsp before cycle %0d expected=none", LAT + 2);
        end
        step();
        #1;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_tag !== 4'd5 || rsp_z !== W'(10)) begin
            errors++;
            $display("FAIL single_rsp rsp_valid=%b tag=%0d z=%0d expected 0100 5 10",
                     rsp_valid, rsp_tag, rsp_z);
        end
        step();
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_z !== W'(10) || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after rsp_valid=%b z=%0d busy=%b expected 0000 10 0",
                     rsp_valid, rsp_z, busy);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_r;
        logic [NREQ-1:0] exp_v;
        int id;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, W'(100 + i), W'(7 * i + 1), TW'(8 + i));
        for (int k = 0; k <= LAT + 10; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_r = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL fair_grant cyc=%0d actual=%b expected=%b", k, req_ready, exp_r);
            end
            checks++;
            if (mul_valid !== (k >= 1 && k <= 8)) begin
                errors++;
                $display("FAIL fair_mul_valid cyc=%0d actual=%b expected=%b",
                         k, mul_valid, (k >= 1 && k <= 8));
            end
            if (k >= 1 && k <= 8) begin
                checks++;
                if (mul_a !== W'(100 + (k - 1) % 4)) begin
                    errors++;
                    $display("FAIL fair_mul_a cyc=%0d actual=%0d expected=%0d",
                             k, mul_a, 100 + (k - 1) % 4);
                end
            end
            id = (k - LAT - 2) % 4;
            exp_v = (k >= LAT + 2 && k <= LAT + 9) ? 4'(1 << id) : 4'b0000;
            checks++;
            if (rsp_valid !== exp_v) begin
                errors++;
                $display("FAIL fair_rsp cyc=%0d actual=%b expected=%b", k, rsp_valid, exp_v);
            end
            if (exp_v != 0) begin
                checks++;
                if (rsp_tag !== TW'(8 + id) || rsp_z !== W'(101 + 8 * id)) begin
                    errors++;
                    $display("FAIL fair_rsp_data cyc=%0d tag=%0d z=%0d expected %0d %0d",
                             k, rsp_tag, rsp_z, 8 + id, 101 + 8 * id);
                end
            end
            if (k == LAT + 10) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL fair_idle actual busy=%b expected=0", busy);
                end
            end
            step();
        end
    endtask

    task automatic test_credit();
        bit exp_r;
        bit exp_v;
        int n;
        apply_reset();
        set_op(0, W'(5), W'(9), 4'd3);
        for (int k = 0; k <= 60; k++) begin
            req_valid = 4'b0001;
            #1;
            exp_r = (k <= 7) || (k >= 51 && k <= 58);
            exp_v = (k >= 50 && k <= 57);
            checks++;
            if (req_ready !== {3'b000, exp_r}) begin
                errors++;
                $display("FAIL credit_ready cyc=%0d actual=%b expected=000%b", k, req_ready, exp_r);
            end
            checks++;
            if (rsp_valid !== {3'b000, exp_v}) begin
                errors++;
                $display("FAIL credit_rsp cyc=%0d actual=%b expected=000%b", k, rsp_valid, exp_v);
            end
            step();
        end
        req_valid = '0;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL credit_drain actual busy=%b after %0d cycles expected=0", busy, n);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        int n;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, W'(40 + i), W'(2), TW'(i));
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'b1111;
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL mid_grant cyc=%0d actual=%b expected=%b",
                         k, req_ready, 4'(1 << (k % 4)));
            end
            step();
        end
        req_valid = '0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || mul_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy_after_reset busy=%b mul_valid=%b expected 0 0", busy, mul_valid);
        end
        seen = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) seen = 1;
            step();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_ghost_rsp actual=activity after reset expected=none");
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_next_grant actual=%b expected=0001", req_ready);
        end
        step();
        req_valid = '0;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain actual busy=%b expected=0", busy);
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int p_m;
        int cnt_m [NREQ];
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] acc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit exp_rsp;
        apply_reset();
        p_m = 0;
        for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
        for (int n = 0; n < RAND_CYC + LAT + 4; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (n < RAND_CYC) && ($urandom_range(3) != 0);
                ra = W'({$urandom, $urandom, $urandom});
                rb = W'({$urandom, $urandom});
                set_op(i, ra, rb, TW'($urandom_range(15)));
            end
            #1;
            eg = '0;
            for (int k = 0; k < NREQ; k++) begin
                int ix;
                ix = (p_m + k) % NREQ;
                if (eg == '0 && req_valid[ix] && cnt_m[ix] < MAX_OUT) eg[ix] = 1'b1;
            end
            checks++;
            if (req_ready !== eg) begin
                errors++;
                $display("FAIL rand_grant cyc=%0d actual=%b expected=%b", n, req_ready, eg);
            end
            exp_rsp = (q.size() > 0) && (q[0].due == n);
            if (exp_rsp) begin
                e = q.pop_front();
                cnt_m[e.id]--;
                checks++;
                if (rsp_valid !== 4'(1 << e.id) || rsp_tag !== e.tag || rsp_z !== e.z) begin
                    errors++;
                    $display("FAIL rand_rsp cyc=%0d valid=%b tag=%0d z=%h expected %b %0d %h",
                             n, rsp_valid, rsp_tag, rsp_z, 4'(1 << e.id), e.tag, e.z);
                end
            end else begin
                checks++;
                if (rsp_valid !== 4'b0000) begin
                    errors++;
                    $display("FAIL rand_spurious_rsp cyc=%0d actual=%b expected=0000", n, rsp_valid);
                end
            end
            acc = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] === 1'b1) begin
                    e.id  = i;
                    e.tag = req_tag[i*TW +: TW];
                    e.z   = req_a[i*W +: W] + req_b[i*W +: W];
                    e.due = n + LAT + 2;
                    q.push_back(e);
                    cnt_m[i]++;
                    p_m = (i + 1) % NREQ;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (cnt_m[i] > MAX_OUT) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_credit cyc=%0d req=%0d outstanding=%0d limit=%0d",
                             n, i, cnt_m[i], MAX_OUT);
                end
            end
            step();
        end
        checks++;
        if (q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain pending=%0d busy=%b expected 0 0", q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_credit();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=completion");
        $fatal(1, "watchdog");
    end

endmodule
